adsr_envelope_generator: RTL and testbench



---
 rtl/adsr_envelope_generator.sv | 155 +++++++++++++++
 tb/tb_adsr_envelope_generator.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope_generator.sv
// Linear ADSR envelope for one voice: a W-bit accumulator stepped once per
// audio tick, with note events handled every clock and registered outputs.
module adsr_envelope_generator #(
  parameter int PARAM_WIDTH    = 7,
  parameter int ENVELOPE_WIDTH = 16,
  parameter int PUSH_BITS      = 8,
  parameter int RATE_SHIFT     = 8
) (
  input  logic                      clock,
  input  logic                      reset_l,
  input  logic                      tick,
  input  logic                      note_on,
  input  logic                      note_off,
  input  logic [PARAM_WIDTH-1:0]    attack_time,
  input  logic [PARAM_WIDTH-1:0]    decay_time,
  input  logic [PARAM_WIDTH-1:0]    sustain_level,
  input  logic [PARAM_WIDTH-1:0]    release_time,
  output logic [ENVELOPE_WIDTH-1:0] envelope,
  output logic [2:0]                phase,
  output logic                      active,
  output logic                      done
);

  localparam int W = ENVELOPE_WIDTH + PUSH_BITS;
  localparam logic [W-1:0] CEIL     = {W{1'b1}};
  localparam logic [W:0]   CEIL_EXT = {1'b0, {W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } phase_t;

  phase_t                r_phase;
  logic [W-1:0]          r_acc;
  logic                  r_active;
  logic                  r_done;

  // Larger time parameter means a smaller per-tick step, so (2^PW - p) scales it.
  function automatic logic [W:0] step_of(input logic [PARAM_WIDTH-1:0] p);
    logic [PARAM_WIDTH:0] span;
    span    = {1'b1, {PARAM_WIDTH{1'b0}}} - {1'b0, p};
    step_of = {{(W - PARAM_WIDTH){1'b0}}, span} << RATE_SHIFT;
  endfunction

  logic [W:0]                w_step_attack;
  logic [W:0]                w_step_decay;
  logic [W:0]                w_step_release;
  logic [ENVELOPE_WIDTH-1:0] w_sus16;
  logic [W-1:0]              w_sus_acc;
  logic [W:0]                w_sus_ext;
  logic [W:0]                w_acc_ext;
  logic                      w_attack_sat;
  logic                      w_decay_hit;
  logic                      w_release_hit;
  logic [W-1:0]              w_acc_up;
  logic [W-1:0]              w_acc_down_decay;
  logic [W-1:0]              w_acc_down_release;
  logic                      w_releasable;

  assign w_step_attack  = step_of(attack_time);
  assign w_step_decay   = step_of(decay_time);
  assign w_step_release = step_of(release_time);

  // Replicating the sustain level MSB-first maps 0 -> 0 and full-scale -> all ones.
  genvar gi;
  generate
    for (gi = 0; gi < ENVELOPE_WIDTH; gi++) begin : g_sus
      assign w_sus16[ENVELOPE_WIDTH-1-gi] = sustain_level[PARAM_WIDTH-1-(gi % PARAM_WIDTH)];
    end
  endgenerate

  assign w_sus_acc = {w_sus16, {PUSH_BITS{1'b0}}};
  assign w_sus_ext = {1'b0, w_sus_acc};
  assign w_acc_ext = {1'b0, r_acc};

  // Compares carry one guard bit so neither end of the range can wrap.
  assign w_attack_sat  = w_acc_ext >= (CEIL_EXT - w_step_attack);
  assign w_decay_hit   = w_acc_ext <= (w_sus_ext + w_step_decay);
  assign w_release_hit = w_acc_ext <= w_step_release;

  assign w_acc_up           = r_acc + w_step_attack[W-1:0];
  assign w_acc_down_decay   = r_acc - w_step_decay[W-1:0];
  assign w_acc_down_release = r_acc - w_step_release[W-1:0];

  assign w_releasable = (r_phase == S_ATTACK) || (r_phase == S_DECAY) ||
                        (r_phase == S_SUSTAIN);

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_acc    <= '0;
      r_phase  <= S_IDLE;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Retrigger keeps the accumulator so the new attack starts from the current level.
      if (note_on) begin
        r_phase  <= S_ATTACK;
        r_active <= 1'b1;
      end else if (note_off && w_releasable) begin
        r_phase  <= S_RELEASE;
        r_active <= 1'b1;
      end else if (tick) begin
        case (r_phase)
          S_IDLE: begin
            r_acc <= '0;
          end
          S_ATTACK: begin
            if (w_attack_sat) begin
              r_acc   <= CEIL;
              r_phase <= S_DECAY;
            end else begin
              r_acc <= w_acc_up;
            end
          end
          S_DECAY: begin
            if (w_decay_hit) begin
              r_acc   <= w_sus_acc;
              r_phase <= S_SUSTAIN;
            end else begin
              r_acc <= w_acc_down_decay;
            end
          end
          S_SUSTAIN: begin
            r_acc <= w_sus_acc;
          end
          S_RELEASE: begin
            if (w_release_hit) begin
              r_acc    <= '0;
              r_phase  <= S_IDLE;
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_acc <= w_acc_down_release;
            end
          end
          default: begin
            r_acc    <= '0;
            r_phase  <= S_IDLE;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign envelope = r_acc[W-1:PUSH_BITS];
  assign phase    = r_phase;
  assign active   = r_active;
  assign done     = r_done;

endmodule

// File: tb/tb_adsr_envelope_generator.sv
// Scenario bench for adsr_envelope_generator: directed envelope timing checks
// plus a randomized run compared cycle by cycle against an arithmetic model.
module tb_adsr_envelope_generator;

  logic        clock = 1'b0;
  logic        reset_l;
  logic        tick;
  logic        note_on;
  logic        note_off;
  logic [6:0]  attack_time;
  logic [6:0]  decay_time;
  logic [6:0]  sustain_level;
  logic [6:0]  release_time;
  logic [15:0] envelope;
  logic [2:0]  phase;
  logic        active;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // model state for the random run
  longint m_acc;
  int     m_phase;
  bit     m_done;

  localparam longint M_CEIL = 64'd16777215;

  adsr_envelope_generator dut (
    .clock         (clock),
    .reset_l       (reset_l),
    .tick          (tick),
    .note_on       (note_on),
    .note_off      (note_off),
    .attack_time   (attack_time),
    .decay_time    (decay_time),
    .sustain_level (sustain_level),
    .release_time  (release_time),
    .envelope      (envelope),
    .phase         (phase),
    .active        (active),
    .done          (done)
  );

  always #5 clock = ~clock;

  function automatic longint m_step(input int p);
    return longint'(128 - p) * 256;
  endfunction

  // sustain level repeated across 16 bits, as an accumulator value
  function automatic longint m_sus(input int s);
    return longint'(((s << 9) | (s << 2) | (s >> 5)) & 16'hFFFF) * 256;
  endfunction

  task automatic cyc(input logic t, input logic on, input logic off);
    tick = t; note_on = on; note_off = off;
    @(posedge clock);
    #1;
    tick = 1'b0; note_on = 1'b0; note_off = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_l = 1'b0;
    @(posedge clock);
    #1;
    reset_l = 1'b1;
  endtask

  task automatic model_apply(input bit t, input bit on, input bit off);
    longint st;
    longint sus;
    m_done = 1'b0;
    if (on) m_phase = 1;
    else if (off && m_phase >= 1 && m_phase <= 3) m_phase = 4;
    else if (t) begin
      case (m_phase)
        1: begin
          st = m_step(int'(attack_time));
          if (m_acc + st >= M_CEIL) begin m_acc = M_CEIL; m_phase = 2; end
          else m_acc = m_acc + st;
        end
        2: begin
          st  = m_step(int'(decay_time));
          sus = m_sus(int'(sustain_level));
          if (m_acc <= sus + st) begin m_acc = sus; m_phase = 3; end
          else m_acc = m_acc - st;
        end
        3: m_acc = m_sus(int'(sustain_level));
        4: begin
          st = m_step(int'(release_time));
          if (m_acc <= st) begin m_acc = 0; m_phase = 0; m_done = 1'b1; end
          else m_acc = m_acc - st;
        end
        default: m_acc = 0;
      endcase
    end
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (envelope !== 16'h0 || phase !== 3'd0 || active !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_held: got env=%h phase=%0d active=%b done=%b, required 0000/0/0/0",
                 envelope, phase, active, done);
      end
    end
    reset_l = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (envelope !== 16'h0 || phase !== 3'd0 || active !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release_idle: got env=%h phase=%0d active=%b, required 0000/0/0",
                 envelope, phase, active);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_attack();
    int k;
    attack_time = 7'd0;
    cyc(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (phase !== 3'd1 || envelope !== 16'h0 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL attack_enter: got phase=%0d env=%h active=%b, required 1/0000/1",
               phase, envelope, active);
    end
    for (k = 1; k < 512; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (phase !== 3'd1 || envelope !== 16'(k * 128)) begin
        n_fail++;
        $display("FAIL attack_ramp tick %0d: got phase=%0d env=%h, required 1/%h",
                 k, phase, envelope, 16'(k * 128));
      end
    end
    cyc(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (phase !== 3'd2 || envelope !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL attack_sat tick 512: got phase=%0d env=%h, required 2/ffff", phase, envelope);
    end
    $display("test_attack: saturated at tick 512");
  endtask

  task automatic test_decay_sustain();
    longint a;
    int     exp_ticks;
    int     k;
    decay_time    = 7'd0;
    sustain_level = 7'h40;
    a = M_CEIL;
    exp_ticks = 1;
    while (a > m_sus(64) + m_step(0)) begin
      a = a - m_step(0);
      exp_ticks++;
    end
    k = 0;
    while (phase != 3'd3 && k < 1000) begin
      cyc(1'b1, 1'b0, 1'b0);
      k++;
    end
    n_checks++;
    if (k !== exp_ticks || envelope !== 16'h8102) begin
      n_fail++;
      $display("FAIL decay_to_sustain: got ticks=%0d env=%h, required %0d/8102",
               k, envelope, exp_ticks);
    end
    sustain_level = 7'h7f;
    cyc(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (envelope !== 16'hFFFF || phase !== 3'd3) begin
      n_fail++;
      $display("FAIL sustain_track_up: got env=%h phase=%0d, required ffff/3", envelope, phase);
    end
    sustain_level = 7'h40;
    cyc(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (envelope !== 16'h8102) begin
      n_fail++;
      $display("FAIL sustain_track_down: got env=%h, required 8102", envelope);
    end
    $display("test_decay_sustain: sustain reached after %0d ticks", k);
  endtask

  task automatic test_release();
    int k;
    release_time = 7'd0;
    cyc(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (phase !== 3'd4 || envelope !== 16'h8102) begin
      n_fail++;
      $display("FAIL release_enter: got phase=%0d env=%h, required 4/8102", phase, envelope);
    end
    k = 0;
    while (k < 400) begin
      cyc(1'b1, 1'b0, 1'b0);
      k++;
      if (phase == 3'd0) break;
      n_checks++;
      if (done !== 1'b0 || active !== 1'b1) begin
        n_fail++;
        $display("FAIL release_early_done tick %0d: got done=%b active=%b, required 0/1",
                 k, done, active);
      end
    end
    n_checks++;
    if (k !== 259 || done !== 1'b1 || active !== 1'b0 || envelope !== 16'h0) begin
      n_fail++;
      $display("FAIL release_end: got tick=%0d done=%b active=%b env=%h, required 259/1/0/0000",
               k, done, active, envelope);
    end
    cyc(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (done !== 1'b0 || phase !== 3'd0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got done=%b phase=%0d, required 0/0", done, phase);
    end
    $display("test_release: idle after %0d ticks", k);
  endtask

  task automatic test_retrigger();
    int     k;
    longint a;
    attack_time   = 7'd0;
    release_time  = 7'd0;
    decay_time    = 7'd0;
    sustain_level = 7'h40;
    cyc(1'b0, 1'b1, 1'b0);
    k = 0;
    while (phase != 3'd2 && k < 600) begin
      cyc(1'b1, 1'b0, 1'b0);
      k++;
    end
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 384; i++) cyc(1'b1, 1'b0, 1'b0);
    a = M_CEIL - 384 * m_step(0);
    n_checks++;
    if (phase !== 3'd4 || envelope !== 16'(a >> 8)) begin
      n_fail++;
      $display("FAIL retrig_release_level: got phase=%0d env=%h, required 4/%h",
               phase, envelope, 16'(a >> 8));
    end
    cyc(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (phase !== 3'd1 || envelope !== 16'(a >> 8)) begin
      n_fail++;
      $display("FAIL retrig_hold: got phase=%0d env=%h, required 1/%h",
               phase, envelope, 16'(a >> 8));
    end
    cyc(1'b1, 1'b0, 1'b0);
    a = a + m_step(0);
    n_checks++;
    if (envelope !== 16'(a >> 8)) begin
      n_fail++;
      $display("FAIL retrig_continue: got env=%h, required %h", envelope, 16'(a >> 8));
    end
    k = 0;
    while (phase != 3'd3 && k < 2000) begin
      cyc(1'b1, 1'b0, 1'b0);
      k++;
    end
    cyc(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (phase !== 3'd1 || envelope !== 16'h8102) begin
      n_fail++;
      $display("FAIL on_off_same_cycle: got phase=%0d env=%h, required 1/8102", phase, envelope);
    end
    $display("test_retrigger: retrigger from %h", 16'((M_CEIL - 384 * m_step(0)) >> 8));
  endtask

  task automatic test_events();
    pulse_reset();
    attack_time  = 7'd0;
    release_time = 7'd0;
    cyc(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (phase !== 3'd0 || envelope !== 16'h0 || done !== 1'b0 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_note_off: got phase=%0d env=%h done=%b active=%b, required 0/0000/0/0",
               phase, envelope, done, active);
    end
    cyc(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (phase !== 3'd1 || envelope !== 16'h0) begin
      n_fail++;
      $display("FAIL event_with_tick_hold: got phase=%0d env=%h, required 1/0000", phase, envelope);
    end
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (phase !== 3'd4 || envelope !== 16'h0500) begin
      n_fail++;
      $display("FAIL note_off_with_tick: got phase=%0d env=%h, required 4/0500", phase, envelope);
    end
    cyc(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (phase !== 3'd4 || envelope !== 16'h0480) begin
      n_fail++;
      $display("FAIL release_note_off_ignored: got phase=%0d env=%h, required 4/0480",
               phase, envelope);
    end
    $display("test_events: done");
  endtask

  task automatic test_async_reset();
    attack_time = 7'd0;
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
    #2;
    reset_l = 1'b0;
    #1;
    n_checks++;
    if (envelope !== 16'h0 || phase !== 3'd0 || active !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got env=%h phase=%0d active=%b done=%b, required 0000/0/0/0",
               envelope, phase, active, done);
    end
    @(posedge clock);
    #1;
    reset_l = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (phase !== 3'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_after: got phase=%0d done=%b, required 0/0", phase, done);
    end
    $display("test_async_reset: done");
  endtask

  task automatic test_slow_attack();
    int k;
    pulse_reset();
    attack_time = 7'd127;
    cyc(1'b0, 1'b1, 1'b0);
    k = 0;
    tick = 1'b1;
    while (phase != 3'd2 && k < 70000) begin
      @(posedge clock);
      #1;
      k++;
    end
    tick = 1'b0;
    n_checks++;
    if (k !== 65536 || envelope !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL slow_attack_sat: got tick=%0d env=%h, required 65536/ffff", k, envelope);
    end
    $display("test_slow_attack: saturated at tick %0d", k);
  endtask

  task automatic test_random();
    bit t, on, off;
    pulse_reset();
    m_acc = 0; m_phase = 0; m_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0: attack_time   = 7'($urandom_range(0, 20));
          1: decay_time    = 7'($urandom_range(0, 20));
          2: sustain_level = 7'($urandom_range(0, 127));
          default: release_time = 7'($urandom_range(0, 20));
        endcase
      end
      t   = ($urandom_range(0, 9) != 0);
      on  = ($urandom_range(0, 399) == 0);
      off = ($urandom_range(0, 299) == 0);
      model_apply(t, on, off);
      cyc(t, on, off);
      n_checks++;
      if (envelope !== 16'(m_acc >> 8) || phase !== 3'(m_phase) ||
          active !== (m_phase != 0) || done !== m_done) begin
        n_fail++;
        $display("FAIL random cycle %0d: got env=%h phase=%0d active=%b done=%b, required %h/%0d/%b/%b",
                 i, envelope, phase, active, done, 16'(m_acc >> 8), m_phase, (m_phase != 0), m_done);
      end
    end
    $display("test_random: 3000 cycles compared");
  endtask

  initial begin
    reset_l = 1'b0; tick = 1'b0; note_on = 1'b0; note_off = 1'b0;
    attack_time = 7'd0; decay_time = 7'd0; sustain_level = 7'h40; release_time = 7'd0;
    test_reset();
    test_attack();
    test_decay_sustain();
    test_release();
    test_retrigger();
    test_events();
    test_async_reset();
    test_slow_attack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
